// File: rtl/aes_job_sequencer_pkg.sv
// Shared types and helpers for the AES job sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_KEY,
        WR_DATA,
        RUN,
        RD,
        RESP
    } state_t;

    localparam logic [1:0] OP_ENC       = 2'b01;
    localparam logic [1:0] OP_DEC       = 2'b10;
    localparam int         CTRL_OWN_BIT = 2;

    // Word 0 is the most significant 32 bits of the vector.
    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
        return v[(3 - int'(i)) * 32 +: 32];
    endfunction

    function automatic logic op_legal(input logic [1:0] op);
        return (op == OP_ENC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/aes_job_sequencer_if.sv
// Job request/response handshake plus the aes_top_level memory/control bus.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes.
// Ports: slave = sequencer view, master = host/datapath view.
interface aes_job_sequencer_if;

    // job request
    logic         req_valid_in;
    logic         req_ready_out;
    logic [127:0] req_key_in;
    logic [127:0] req_block_in;
    logic [1:0]   req_op_in;
    logic         req_key_reuse_in;
    // job response
    logic         resp_valid_out;
    logic         resp_ready_in;
    logic [127:0] resp_block_out;
    logic         resp_err_out;
    // aes_top_level side
    logic [2:0]   aes_ctrl_out;
    logic [31:0]  aes_wdata_out;
    logic [3:0]   aes_mem_we_out;
    logic [9:0]   aes_mem_rd_addr_out;
    logic [9:0]   aes_mem_wr_addr_out;
    logic [31:0]  aes_rdata_in;
    logic         aes_complete_in;
    // status
    logic         busy_out;

    modport slave (
        input  req_valid_in, req_key_in, req_block_in, req_op_in, req_key_reuse_in,
        input  resp_ready_in, aes_rdata_in, aes_complete_in,
        output req_ready_out, resp_valid_out, resp_block_out, resp_err_out,
        output aes_ctrl_out, aes_wdata_out, aes_mem_we_out,
        output aes_mem_rd_addr_out, aes_mem_wr_addr_out, busy_out
    );

    modport master (
        output req_valid_in, req_key_in, req_block_in, req_op_in, req_key_reuse_in,
        output resp_ready_in, aes_rdata_in, aes_complete_in,
        input  req_ready_out, resp_valid_out, resp_block_out, resp_err_out,
        input  aes_ctrl_out, aes_wdata_out, aes_mem_we_out,
        input  aes_mem_rd_addr_out, aes_mem_wr_addr_out, busy_out
    );

endinterface

// File: rtl/aes_job_sequencer.sv
// Runs one AES job: write key/block to aes_mem, hand memory to the core, read result back.
// Latency: fresh key T+9 to RUN, result C+6 after complete; key reuse 4 less; illegal op T+1.
// Backpressure: one job in flight; req_ready only in IDLE; response held until resp_ready.
// Ports: clk_in, rst_n_in (async active-low), bus (aes_job_sequencer_if.slave).
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter logic [9:0] KEY_BASE       = 10'd0,
    parameter logic [9:0] DIN_BASE       = 10'd4,
    parameter logic [9:0] DOUT_BASE      = 10'd8,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    aes_job_sequencer_if.slave bus
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t       r_state;
    state_t       w_next;
    logic [2:0]   r_cnt;
    logic [15:0]  r_tmo;
    logic [127:0] r_key;
    logic [127:0] r_blk;
    logic [127:0] r_res;
    logic [1:0]   r_op;
    logic         r_err;
    logic         r_key_vld;

    logic         w_req_rdy;
    logic         w_resp_vld;
    logic [2:0]   w_ctrl;
    logic [31:0]  w_wdata;
    logic [3:0]   w_we;
    logic [9:0]   w_rd_addr;
    logic [9:0]   w_wr_addr;
    logic         w_busy;
    logic         w_accept;
    logic         w_tmo_hit;
    logic [1:0]   w_rd_idx;

    assign w_accept  = bus.req_valid_in && (r_state == IDLE);
    assign w_tmo_hit = (r_tmo == TMO_LAST);
    // Read data lags the address by one cycle, so count n captures word n-1.
    assign w_rd_idx  = 2'(r_cnt - 3'd1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_req_rdy = 1'b0;
        w_resp_vld = 1'b0;
        w_ctrl    = 3'b000;
        w_wdata   = 32'd0;
        w_we      = 4'h0;
        w_rd_addr = 10'd0;
        w_wr_addr = 10'd0;
        w_busy    = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy    = 1'b0;
                w_req_rdy = 1'b1;
                if (bus.req_valid_in) begin
                    if (!op_legal(bus.req_op_in)) begin
                        w_next = RESP;
                    end else if (bus.req_key_reuse_in && r_key_vld) begin
                        w_next = WR_DATA;
                    end else begin
                        w_next = WR_KEY;
                    end
                end
            end
            WR_KEY: begin
                w_we      = 4'hF;
                w_wr_addr = KEY_BASE + 10'(r_cnt[1:0]);
                w_wdata   = word_of(r_key, r_cnt[1:0]);
                if (r_cnt == 3'd3) w_next = WR_DATA;
            end
            WR_DATA: begin
                w_we      = 4'hF;
                w_wr_addr = DIN_BASE + 10'(r_cnt[1:0]);
                w_wdata   = word_of(r_blk, r_cnt[1:0]);
                if (r_cnt == 3'd3) w_next = RUN;
            end
            RUN: begin
                w_ctrl[CTRL_OWN_BIT] = 1'b1;
                w_ctrl[1:0]          = r_op;
                // Completion takes priority over a timeout landing on the same cycle.
                if (bus.aes_complete_in) begin
                    w_next = RD;
                end else if (w_tmo_hit) begin
                    w_next = RESP;
                end
            end
            RD: begin
                if (r_cnt != 3'd4) begin
                    w_rd_addr = DOUT_BASE + 10'(r_cnt[1:0]);
                end else begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_resp_vld = 1'b1;
                if (bus.resp_ready_in) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt     <= 3'd0;
            r_tmo     <= 16'd0;
            r_key     <= '0;
            r_blk     <= '0;
            r_res     <= '0;
            r_op      <= 2'b00;
            r_err     <= 1'b0;
            r_key_vld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 3'd0;
                    r_tmo <= 16'd0;
                    if (w_accept) begin
                        r_key <= bus.req_key_in;
                        r_blk <= bus.req_block_in;
                        r_op  <= bus.req_op_in;
                        r_res <= '0;
                        r_err <= !op_legal(bus.req_op_in);
                    end
                end
                WR_KEY: begin
                    if (r_cnt == 3'd3) begin
                        r_cnt     <= 3'd0;
                        r_key_vld <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                WR_DATA: begin
                    r_cnt <= (r_cnt == 3'd3) ? 3'd0 : r_cnt + 3'd1;
                end
                RUN: begin
                    r_tmo <= r_tmo + 16'd1;
                    if (!bus.aes_complete_in && w_tmo_hit) begin
                        // The core may have left memory in any state; force a key rewrite.
                        r_err     <= 1'b1;
                        r_res     <= '0;
                        r_key_vld <= 1'b0;
                    end
                end
                RD: begin
                    if (r_cnt != 3'd0) begin
                        r_res[(3 - int'(w_rd_idx)) * 32 +: 32] <= bus.aes_rdata_in;
                    end
                    r_cnt <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready_out       = w_req_rdy;
    assign bus.resp_valid_out      = w_resp_vld;
    assign bus.resp_block_out      = r_res;
    assign bus.resp_err_out        = r_err;
    assign bus.aes_ctrl_out        = w_ctrl;
    assign bus.aes_wdata_out       = w_wdata;
    assign bus.aes_mem_we_out      = w_we;
    assign bus.aes_mem_rd_addr_out = w_rd_addr;
    assign bus.aes_mem_wr_addr_out = w_wr_addr;
    assign bus.busy_out            = w_busy;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Bench for aes_job_sequencer: aes_mem/core stub, response scoreboard, directed + random jobs.
// Latency: checks response rise cycle against the job-level timing rules.
// Backpressure: random resp_ready, plus a 10-cycle hold on one job.
module tb_aes_job_sequencer;
    import aes_seq_pkg::*;

    localparam int TMO   = 24;
    localparam int NEVER = 1000;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_job_sequencer_if bus();

    aes_job_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [127:0] blk;
        logic         err;
        int           rise;
        int           key_wr;
        int           dat_wr;
        int           run_len;
    } exp_t;

    exp_t exq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // stub / environment state
    logic [31:0]  mem [0:15];
    logic [9:0]   rd_prev;
    logic [1:0]   cur_op = 2'b00;
    int           cur_d = NEVER;
    logic         spur = 1'b0;
    logic         bp_hold = 1'b0;
    int           run_cnt, last_run, key_wr, dat_wr, we_bad, ctrl_bad, hold_left;
    logic         in_resp;
    logic [127:0] held_blk;
    logic         held_err;
    logic [127:0] res_w;
    logic         rdy;

    // reference model state
    logic [127:0] resident_key = '0;
    logic         kv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Stand-in for the AES core: any function of key, block and op exposes
    // misdelivered words; the FIPS-197 vector is answered with its real ciphertext.
    function automatic logic [127:0] stand_in(input logic [127:0] k, input logic [127:0] b,
                                              input logic [1:0] op);
        if (k == FIPS_KEY && b == FIPS_PT && op == OP_ENC) return FIPS_CT;
        if (op == OP_ENC) return b ^ k ^ {4{32'hA5A55A5A}};
        return {b[63:0], b[127:64]} ^ ~k;
    endfunction

    // Environment: memory + core stub and the response monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] = 32'd0;
            rd_prev = 10'd0;
            run_cnt = 0; last_run = 0; key_wr = 0; dat_wr = 0; we_bad = 0; ctrl_bad = 0;
            hold_left = 0; in_resp = 1'b0;
            bus.aes_rdata_in    = 32'd0;
            bus.aes_complete_in = 1'b0;
            bus.resp_ready_in   = 1'b0;
        end else begin
            bus.aes_rdata_in = mem[rd_prev[3:0]];
            if (bus.aes_mem_rd_addr_out > 10'd15) we_bad++;
            rd_prev = bus.aes_mem_rd_addr_out;

            if (bus.aes_mem_we_out != 4'h0) begin
                if (bus.aes_mem_we_out == 4'hF && bus.aes_mem_wr_addr_out < 10'd8) begin
                    mem[bus.aes_mem_wr_addr_out[3:0]] = bus.aes_wdata_out;
                    if (bus.aes_mem_wr_addr_out < 10'd4) key_wr++;
                    else dat_wr++;
                end else begin
                    we_bad++;
                end
            end

            if (bus.aes_ctrl_out[2]) begin
                run_cnt++;
                if (bus.aes_ctrl_out[1:0] != cur_op || !op_legal(cur_op)) ctrl_bad++;
                if (bus.aes_mem_we_out != 4'h0) we_bad++;
                bus.aes_complete_in = ((run_cnt - 1) == cur_d);
                if (bus.aes_complete_in) begin
                    res_w = stand_in({mem[0], mem[1], mem[2], mem[3]},
                                     {mem[4], mem[5], mem[6], mem[7]}, bus.aes_ctrl_out[1:0]);
                    for (int i = 0; i < 4; i++) mem[8 + i] = res_w[(3 - i) * 32 +: 32];
                end
            end else begin
                if (bus.aes_ctrl_out != 3'b000) ctrl_bad++;
                if (run_cnt > 0) last_run = run_cnt;
                run_cnt = 0;
                bus.aes_complete_in = spur && bus.busy_out;
            end

            rdy = 1'b0;
            if (bus.resp_valid_out) begin
                if (!in_resp) begin
                    in_resp  = 1'b1;
                    held_blk = bus.resp_block_out;
                    held_err = bus.resp_err_out;
                    hold_left = bp_hold ? 10 : 0;
                    bp_hold  = 1'b0;
                    chk("queue_depth", 128'(exq.size()), 128'(1));
                    if (exq.size() > 0) chk("resp_rise_cycle", 128'(cyc), 128'(exq[0].rise));
                end else begin
                    chk("resp_block_stable", bus.resp_block_out, held_blk);
                    chk("resp_err_stable", 128'(bus.resp_err_out), 128'(held_err));
                end
                if (hold_left > 0) begin
                    chk("req_ready_low_in_resp", 128'(bus.req_ready_out), 128'(0));
                    hold_left--;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
                if (rdy && exq.size() > 0) begin
                    chk("resp_block", bus.resp_block_out, exq[0].blk);
                    chk("resp_err", 128'(bus.resp_err_out), 128'(exq[0].err));
                    chk("key_writes", 128'(key_wr), 128'(exq[0].key_wr));
                    chk("data_writes", 128'(dat_wr), 128'(exq[0].dat_wr));
                    chk("run_cycles", 128'(last_run), 128'(exq[0].run_len));
                    chk("stray_we_or_addr", 128'(we_bad), 128'(0));
                    chk("ctrl_value", 128'(ctrl_bad), 128'(0));
                    void'(exq.pop_front());
                    key_wr = 0; dat_wr = 0; we_bad = 0; ctrl_bad = 0; last_run = 0;
                    in_resp = 1'b0;
                end
            end
            bus.resp_ready_in = rdy;
        end
    end

    // Issue one job and, if push is set, queue the response the job rules predict.
    task automatic send(input logic [1:0] op, input logic reuse, input int d,
                        input logic [127:0] key, input logic [127:0] blk, input logic push);
        exp_t e;
        int   t;
        int   guard;
        logic fresh;
        int   base;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready_out) begin
            @(negedge clk);
            guard++;
            if (guard > 400) begin
                checks++; errors++;
                $display("FAIL req_accept_timeout: req_ready_out stuck at 0 for %0d cycles", guard);
                return;
            end
        end
        cur_op = op;
        cur_d  = d;
        bus.req_valid_in     = 1'b1;
        bus.req_key_in       = key;
        bus.req_block_in     = blk;
        bus.req_op_in        = op;
        bus.req_key_reuse_in = reuse;
        t = cyc;
        if (op_legal(op)) begin
            fresh = !(reuse && kv);
            if (fresh) begin
                resident_key = key;
                kv = 1'b1;
            end
            base     = t + (fresh ? 9 : 5);
            e.key_wr = fresh ? 4 : 0;
            e.dat_wr = 4;
            if (d < TMO) begin
                e.blk = stand_in(resident_key, blk, op);
                e.err = 1'b0;
                e.rise = base + d + 6;
                e.run_len = d + 1;
            end else begin
                e.blk = '0;
                e.err = 1'b1;
                e.rise = base + TMO;
                e.run_len = TMO;
                kv = 1'b0;
            end
        end else begin
            e.blk = '0; e.err = 1'b1; e.rise = t + 1;
            e.key_wr = 0; e.dat_wr = 0; e.run_len = 0;
        end
        if (push) exq.push_back(e);
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        bus.req_key_in   = {$urandom, $urandom, $urandom, $urandom};
        bus.req_block_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exq.size() > 0) begin
            @(negedge clk);
            guard++;
            if (guard > 600) begin
                checks++; errors++;
                $display("FAIL drain_timeout: %0d responses still outstanding", exq.size());
                exq.delete();
            end
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [1:0] op;
        int         sel;
        int         guard;
        bus.req_valid_in     = 1'b0;
        bus.req_key_in       = '0;
        bus.req_block_in     = '0;
        bus.req_op_in        = 2'b00;
        bus.req_key_reuse_in = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 128'(bus.req_ready_out), 128'(1));
        chk("rst_resp_valid", 128'(bus.resp_valid_out), 128'(0));
        chk("rst_busy", 128'(bus.busy_out), 128'(0));
        chk("rst_ctrl", 128'(bus.aes_ctrl_out), 128'(0));
        chk("rst_we", 128'(bus.aes_mem_we_out), 128'(0));
        chk("rst_addrs", 128'({bus.aes_mem_rd_addr_out, bus.aes_mem_wr_addr_out}), 128'(0));
        chk("rst_resp_fields", {bus.resp_block_out[126:0], bus.resp_err_out}, 128'(0));
        rst_n = 1'b1;

        // FIPS-197 encrypt with a fresh key, then the same key reused under backpressure.
        send(OP_ENC, 1'b0, 20, FIPS_KEY, FIPS_PT, 1'b1);
        send(OP_ENC, 1'b1, 20, 128'h0, FIPS_PT, 1'b1);
        bp_hold = 1'b1;
        wait_drain();

        // Timeout, then a reuse request that must still rewrite the key.
        send(OP_DEC, 1'b0, NEVER, rnd128(), rnd128(), 1'b1);
        send(OP_DEC, 1'b1, 5, rnd128(), rnd128(), 1'b1);

        // Illegal ops.
        send(2'b11, 1'b0, 3, rnd128(), rnd128(), 1'b1);
        send(2'b00, 1'b1, 3, rnd128(), rnd128(), 1'b1);
        wait_drain();

        // Spurious complete outside RUN must be ignored.
        spur = 1'b1;
        send(OP_ENC, 1'b1, 3, rnd128(), rnd128(), 1'b1);
        wait_drain();
        spur = 1'b0;

        // Completion on the last allowed cycle beats the timeout; immediate completion.
        send(OP_ENC, 1'b0, TMO - 1, rnd128(), rnd128(), 1'b1);
        send(OP_DEC, 1'b1, 0, rnd128(), rnd128(), 1'b1);
        wait_drain();

        // Reset while the core owns memory: no response, back to idle, key forgotten.
        send(OP_ENC, 1'b0, NEVER, rnd128(), rnd128(), 1'b0);
        guard = 0;
        while (!bus.aes_ctrl_out[2] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_run", 128'(bus.aes_ctrl_out[2]), 128'(1));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ctrl_async_reset", 128'(bus.aes_ctrl_out), 128'(0));
        chk("busy_async_reset", 128'(bus.busy_out), 128'(0));
        kv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 128'(bus.req_ready_out), 128'(1));
        chk("post_rst_resp_valid", 128'(bus.resp_valid_out), 128'(0));
        repeat (10) @(negedge clk);
        send(OP_ENC, 1'b1, 4, rnd128(), rnd128(), 1'b1);
        wait_drain();

        // Random jobs.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 7);
            op = (sel < 3) ? OP_ENC : (sel < 6) ? OP_DEC : (sel == 6) ? 2'b00 : 2'b11;
            send(op, 1'($urandom_range(0, 1)), $urandom_range(0, TMO + 4),
                 rnd128(), rnd128(), 1'b1);
        end
        wait_drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
